// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  // Debounce counter width; a single-cycle filter still needs one bit.
  function automatic int cnt_width(int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser chain, consecutive-sample debounce filter and
// registered one-clock rise/fall/mode-selected edge pulses.
module edge_chan
  import edge_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_i,
  input  logic [1:0] mode_i,
  output logic       stable_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       edge_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   edge_q, edge_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    edge_d   = 1'b0;
    if (sync_out == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      // Enough consecutive differing samples: accept the new level.
      cnt_d    = '0;
      stable_d = sync_out;
      rise_d   = sync_out;
      fall_d   = ~sync_out;
      case (edge_mode_t'(mode_i))
        EDGE_RISE: edge_d = sync_out;
        EDGE_FALL: edge_d = ~sync_out;
        EDGE_BOTH: edge_d = 1'b1;
        default:   edge_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      stable_q <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= edge_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_o   = edge_q;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel debounced edge detector: one independent edge_chan per input
// pin plus a combined any_edge flag.
module multi_edge_detect #(
  parameter int   NUM_CH          = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig,
  input  logic [1:0]        mode,
  output logic [NUM_CH-1:0] sig_stable,
  output logic [NUM_CH-1:0] sig_rise,
  output logic [NUM_CH-1:0] sig_fall,
  output logic [NUM_CH-1:0] sig_edge,
  output logic              any_edge
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_i   (sig[i]),
      .mode_i  (mode),
      .stable_o(sig_stable[i]),
      .rise_o  (sig_rise[i]),
      .fall_o  (sig_fall[i]),
      .edge_o  (sig_edge[i])
    );
  end

  // Purely an OR of registered pulses, so it is glitch-free in practice.
  assign any_edge = |sig_edge;

endmodule
